map_tile_renderer: RTL and testbench
====================================

# map_tile_renderer

Parametrised, RAM-backed successor to the hard-coded maze drawers. It renders a tile map for the VGA pixel stream and answers tile-type queries for the ball physics. The map has a configurable tile size and grid, and multiple levels are loaded at run time from an external level ROM by a loader FSM. It sits between the VGA sync counter (x, y) and the pixel mux, and shares the tile store with the collision logic.

## Interface
- TILE_LOG2, 4: log2 of tile edge in pixels (4 gives 16×16 tiles).
- MAPX_LOG2, 5: log2 of map width in tiles.
- MAPY_LOG2, 5: log2 of map height in tiles.
- LVL_LOG2, 2: log2 of level count.
- GOAL_COLOR, 12'h0F0: colour for goal tiles.

Ports:
- clk  in  1  pixel clock. One clock domain; reset is asynchronous and active-high.
- rst  in  1  asynchronous, active-high reset.
- x, y  in  11 each  pixel coordinate from the sync counter.
- color  out  12  registered pixel colour.
- level  in  LVL_LOG2  level to load; sampled when load is accepted.
- load  in  1  one-cycle load request.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse when a load completes.
- rom_addr  out  LVL_LOG2+MAPX_LOG2+MAPY_LOG2  level ROM address, {level, ty, tx}.
- rom_data  in  2  tile code; valid one cycle after rom_addr.
- qx, qy  in  11 each  physics query pixel coordinate.
- q_tile  out  2  tile code at (qx, qy).

## Operation
- Tile codes:
  - 0: GROUND, colour `GROUND.
  - 1: WALL, colour `WALL.
  - 2: BOUND, colour `BOUND.
  - 3: GOAL, colour GOAL_COLOR.
- Tile store: 2^(MAPX_LOG2+MAPY_LOG2) entries × 2 bits. One write port (loader) and two synchronous read ports (pixel, query). Contents are not reset.
- Tile index for a coordinate: tx = x[TILE_LOG2 +: MAPX_LOG2], ty = y[TILE_LOG2 +: MAPY_LOG2].
- Outside: x ≥ 2^(TILE_LOG2+MAPX_LOG2), or y ≥ 2^(TILE_LOG2+MAPY_LOG2), or bit 10 of either coordinate set.
  - Pixel port: colour `NULL.
  - Query port: q_tile = 2 (BOUND).
- map_valid flag: cleared by reset and at load accept; set when done pulses.
  - While map_valid = 0: color = `NULL and q_tile = 2 for every coordinate.
- Loader FSM:
  - IDLE: on load, latch level, go to FILL, raise busy.
  - FILL: rom_addr steps through indices 0 .. N−1, where N = 2^(MAPX_LOG2+MAPY_LOG2), one per cycle. Each rom_data is written to index (addr−1) on the following cycle. After issuing N−1, go to LAST.
  - LAST: write the final entry, go to FIN.
  - FIN: pulse done, clear busy, set map_valid, go to IDLE.
- load while busy: ignored; the level latch is unchanged.
- rom_addr in IDLE holds its last value; the ROM tolerates any address.

## Timing
- Reset values:
  - color = `NULL, q_tile = 2.
  - busy = 0, done = 0, rom_addr = 0.
  - FSM = IDLE, map_valid = 0.
- Pixel latency: 2 cycles. Cycle 1 registers the tile index and outside flag and reads the RAM; cycle 2 registers color. The query path has the same 2-cycle latency into q_tile.
- Load accepted at edge 0 (load = 1, FSM in IDLE):
  - busy = 1 after edge 0.
  - rom_addr = {level, 0} after edge 0, incrementing each edge.
  - The last write happens at edge N+1; done = 1 and busy = 0 after edge N+2. done lasts exactly one cycle.
  - Total busy time: N+2 cycles (1026 at defaults).
- A load request in the same cycle as done is not accepted; the FSM must be in IDLE.
- Reset mid-load: FSM returns to IDLE immediately, busy and map_valid drop asynchronously, and no done pulse is produced.
- Pixel and query reads during FILL return NULL/BOUND because map_valid = 0, regardless of partial RAM contents.

## Test plan
- Reset: assert rst mid-frame → color = `NULL, q_tile = 2, busy = 0 within the same cycle; these hold until the first load completes.
- Load and render level 1 with the ROM model, defaults: load pulse → busy for 1026 cycles, rom_addr runs 0x400..0x7FF, single done pulse. Then x = 85, y = 40 (tile 5,2, ROM code 1) gives color = `WALL two cycles later.
- Bounds: after a valid load, x = 512, y = 0 → color `NULL; x = 1024 → `NULL; qx = 600 → q_tile = 2; x = 511, y = 511 → tile (31,31) colour.
- Load while busy: second load with level = 3 at cycle 100 of a level-2 load → no effect; the level-2 map loads and done pulses once at cycle 1026.
- Reset mid-load at cycle 500 → busy falls immediately, no done. A new load of level 0 then completes normally with the level-0 map.
- Parameter sweep TILE_LOG2 = 3, MAPX_LOG2 = 4, MAPY_LOG2 = 4: N = 256, busy lasts 258 cycles, and x = 128 is outside.

Source files
------------

// File: rtl/map_tile_renderer.sv
// RAM-backed tile map renderer: a loader FSM copies a level from the external ROM
// into the tile store, which then feeds the VGA pixel path and the physics query port.
`ifndef GROUND
`define GROUND 12'h333
`endif
`ifndef WALL
`define WALL 12'h888
`endif
`ifndef BOUND
`define BOUND 12'hF00
`endif
`ifndef NULL
`define NULL 12'h000
`endif

module map_tile_renderer #(
    parameter int          TILE_LOG2  = 4,
    parameter int          MAPX_LOG2  = 5,
    parameter int          MAPY_LOG2  = 5,
    parameter int          LVL_LOG2   = 2,
    parameter logic [11:0] GOAL_COLOR = 12'h0F0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [10:0]                               x,
    input  logic [10:0]                               y,
    output logic [11:0]                               color,
    input  logic [LVL_LOG2-1:0]                       level,
    input  logic                                      load,
    output logic                                      busy,
    output logic                                      done,
    output logic [LVL_LOG2+MAPX_LOG2+MAPY_LOG2-1:0]   rom_addr,
    input  logic [1:0]                                rom_data,
    input  logic [10:0]                               qx,
    input  logic [10:0]                               qy,
    output logic [1:0]                                q_tile
);
    localparam int          IW    = MAPX_LOG2 + MAPY_LOG2;
    localparam int          N     = 1 << IW;
    localparam logic [11:0] X_END = 12'd1 << (TILE_LOG2 + MAPX_LOG2);
    localparam logic [11:0] Y_END = 12'd1 << (TILE_LOG2 + MAPY_LOG2);

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_LAST, ST_FIN} state_t;

    state_t              state_q, state_d;
    logic [LVL_LOG2-1:0] lvl_q, lvl_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       wr_idx_q, wr_idx_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                valid_q, valid_d;
    logic [11:0]         color_q, color_d;
    logic [1:0]          q_tile_q, q_tile_d;

    logic [1:0]          tile_mem [N];

    // The ROM answers one cycle after the address, so each write trails its address by one stage.
    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        done_d   = 1'b0;
        wr_en_d  = (state_q == ST_FILL);
        wr_idx_d = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (load && !done_q) begin
                    lvl_d   = level;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                if (idx_q == {IW{1'b1}}) begin
                    state_d = ST_LAST;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_LAST: state_d = ST_FIN;
            ST_FIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lvl_q    <= '0;
            idx_q    <= '0;
            wr_idx_q <= '0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            idx_q    <= idx_d;
            wr_idx_q <= wr_idx_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            tile_mem[wr_idx_q] <= rom_data;
        end
    end

    // Port 0 serves the pixel stream, port 1 the physics query.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [10:0]   cx, cy;
            logic [IW-1:0] idx_rd;
            logic          out_d, out_q;
            logic [1:0]    tile_q;

            assign cx = (gi == 0) ? x : qx;
            assign cy = (gi == 0) ? y : qy;

            always_comb begin
                idx_rd = {cy[TILE_LOG2 +: MAPY_LOG2], cx[TILE_LOG2 +: MAPX_LOG2]};
                out_d  = cx[10] | cy[10] | ({1'b0, cx} >= X_END) | ({1'b0, cy} >= Y_END);
            end

            always_ff @(posedge clk) begin
                tile_q <= tile_mem[idx_rd];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_q <= 1'b1;
                end else begin
                    out_q <= out_d;
                end
            end
        end
    endgenerate

    always_comb begin
        color_d  = `NULL;
        q_tile_d = 2'd2;
        if (valid_q && !g_rd[0].out_q) begin
            case (g_rd[0].tile_q)
                2'd0:    color_d = `GROUND;
                2'd1:    color_d = `WALL;
                2'd2:    color_d = `BOUND;
                default: color_d = GOAL_COLOR;
            endcase
        end
        if (valid_q && !g_rd[1].out_q) begin
            q_tile_d = g_rd[1].tile_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            color_q  <= `NULL;
            q_tile_q <= 2'd2;
        end else begin
            color_q  <= color_d;
            q_tile_q <= q_tile_d;
        end
    end

    assign color    = color_q;
    assign q_tile   = q_tile_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign rom_addr = {lvl_q, idx_q};
endmodule

// File: tb/tb_map_tile_renderer.sv
// Directed bench for map_tile_renderer: default-size and small-grid instances, each fed by
// a synchronous level ROM whose tile code is (tx + ty + bitswap(level)) mod 4.
module tb_map_tile_renderer;
    localparam logic [11:0] C_NULL   = 12'h000;
    localparam logic [11:0] C_GROUND = 12'h333;
    localparam logic [11:0] C_WALL   = 12'h888;
    localparam logic [11:0] C_BOUND  = 12'hF00;
    localparam logic [11:0] C_GOAL   = 12'h0F0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [10:0] x_a = '0, y_a = '0, qx_a = '0, qy_a = '0;
    logic [11:0] color_a;
    logic [1:0]  level_a = '0;
    logic        load_a = 1'b0, busy_a, done_a;
    logic [11:0] rom_addr_a;
    logic [1:0]  rom_data_a = '0;
    logic [1:0]  q_tile_a;

    logic [10:0] x_b = '0, y_b = '0, qx_b = '0, qy_b = '0;
    logic [11:0] color_b;
    logic [1:0]  level_b = '0;
    logic        load_b = 1'b0, busy_b, done_b;
    logic [9:0]  rom_addr_b;
    logic [1:0]  rom_data_b = '0;
    logic [1:0]  q_tile_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [11:0] col;
        logic [1:0]  qt;
    } exp_t;
    exp_t sb[$];

    map_tile_renderer dut_a (
        .clk(clk), .rst(rst), .x(x_a), .y(y_a), .color(color_a), .level(level_a),
        .load(load_a), .busy(busy_a), .done(done_a), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .qx(qx_a), .qy(qy_a), .q_tile(q_tile_a)
    );

    map_tile_renderer #(.TILE_LOG2(3), .MAPX_LOG2(4), .MAPY_LOG2(4)) dut_b (
        .clk(clk), .rst(rst), .x(x_b), .y(y_b), .color(color_b), .level(level_b),
        .load(load_b), .busy(busy_b), .done(done_b), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .qx(qx_b), .qy(qy_b), .q_tile(q_tile_b)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] rom_code(input logic [1:0] lvl, input int ty, input int tx);
        return 2'(tx + ty + int'({lvl[0], lvl[1]}));
    endfunction

    always @(posedge clk) begin
        rom_data_a <= rom_code(rom_addr_a[11:10], int'(rom_addr_a[9:5]), int'(rom_addr_a[4:0]));
        rom_data_b <= rom_code(rom_addr_b[9:8], int'(rom_addr_b[7:4]), int'(rom_addr_b[3:0]));
    end

    function automatic logic [11:0] col_of(input logic [1:0] c);
        case (c)
            2'd0:    return C_GROUND;
            2'd1:    return C_WALL;
            2'd2:    return C_BOUND;
            default: return C_GOAL;
        endcase
    endfunction

    // -1 means outside the map.
    function automatic int model_code(input int sel, input logic [1:0] lvl, input int px, input int py);
        int tl, ml;
        tl = (sel != 0) ? 3 : 4;
        ml = (sel != 0) ? 4 : 5;
        if (px >= (1 << (tl + ml)) || py >= (1 << (tl + ml))) return -1;
        return int'(rom_code(lvl, (py >> tl) & ((1 << ml) - 1), (px >> tl) & ((1 << ml) - 1)));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? busy_b : busy_a;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel != 0) ? done_b : done_a;
    endfunction

    function automatic logic [31:0] addr_of(input int sel);
        return (sel != 0) ? 32'(rom_addr_b) : 32'(rom_addr_a);
    endfunction

    task automatic drive_load(input int sel, input logic ld, input logic [1:0] lvl);
        if (sel != 0) begin
            load_b = ld; level_b = lvl;
        end else begin
            load_a = ld; level_a = lvl;
        end
    endtask

    task automatic drive_xy(input int sel, input int px, input int py, input int qpx, input int qpy);
        if (sel != 0) begin
            x_b = 11'(px); y_b = 11'(py); qx_b = 11'(qpx); qy_b = 11'(qpy);
        end else begin
            x_a = 11'(px); y_a = 11'(py); qx_a = 11'(qpx); qy_a = 11'(qpy);
        end
    endtask

    task automatic pop_check(input int sel);
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_color"}, 32'((sel != 0) ? color_b : color_a), 32'(e.col));
        chk({e.tag, "_qtile"}, 32'((sel != 0) ? q_tile_b : q_tile_a), 32'(e.qt));
    endtask

    task automatic pix(input int sel, input string tag, input int px, input int py,
                       input int qpx, input int qpy, input logic [11:0] ecol, input logic [1:0] eq);
        drive_xy(sel, px, py, qpx, qpy);
        sb.push_back('{tag, ecol, eq});
        step();
        step();
        pop_check(sel);
    endtask

    // Issues a load at the next edge (edge 0) and follows it for n+12 cycles.
    task automatic watch_load(input int sel, input string tag, input logic [1:0] lvl, input int n,
                              input int extra_at, input logic [1:0] extra_lvl, input int abort_at);
        int  busy_cyc, dones, done_k, aw;
        bit  addr_ok;
        busy_cyc = 0; dones = 0; done_k = -1; addr_ok = 1'b1;
        aw = (sel != 0) ? 8 : 10;
        drive_load(sel, 1'b1, lvl);
        step();
        drive_load(sel, 1'b0, 2'd0);
        for (int k = 0; k < n + 12; k++) begin
            if (abort_at >= 0 && k == abort_at + 1) rst = 1'b0;
            if (busy_of(sel)) busy_cyc++;
            if (done_of(sel)) begin dones++; done_k = k; end
            if (k < n && (abort_at < 0 || k <= abort_at) &&
                addr_of(sel) !== ((32'(lvl) << aw) | 32'(k))) addr_ok = 1'b0;
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1 chk({tag, "_abort_busy"}, 32'(busy_of(sel)), 32'd0);
            end
            if (k == extra_at - 1 || (abort_at < 0 && k == n + 2)) drive_load(sel, 1'b1, extra_lvl);
            else drive_load(sel, 1'b0, 2'd0);
            step();
        end
        drive_load(sel, 1'b0, 2'd0);
        chk({tag, "_rom_addr_seq"}, 32'(addr_ok), 32'd1);
        if (abort_at < 0) begin
            chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(n + 2));
            chk({tag, "_done_count"}, 32'(dones), 32'd1);
            chk({tag, "_done_cycle"}, 32'(done_k), 32'(n + 2));
        end else begin
            chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'(abort_at + 1));
            chk({tag, "_done_count"}, 32'(dones), 32'd0);
        end
    endtask

    initial begin
        int px_l [8] = '{0, 17, 200, 300, 511, 0, 513, 40};
        int py_l [8] = '{0, 33, 100, 480, 0, 511, 3, 1030};
        int c;

        // Reset held for a few cycles, then released with no map loaded.
        step(); step(); step();
        chk("rst_color", 32'(color_a), 32'(C_NULL));
        chk("rst_qtile", 32'(q_tile_a), 32'd2);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr_a), 32'd0);
        rst = 1'b0;
        step();
        pix(0, "noload", 85, 40, 85, 40, C_NULL, 2'd2);

        // Level 1; a load raised in the done cycle must be refused.
        watch_load(0, "load_l1", 2'd1, 1024, -1, 2'd3, -1);
        pix(0, "l1_tile_5_2", 85, 40, 85, 40, C_WALL, 2'd1);
        pix(0, "bound_x512", 512, 0, 600, 0, C_NULL, 2'd2);
        pix(0, "bound_x1024", 1024, 5, 1024, 5, C_NULL, 2'd2);
        pix(0, "tile_31_31", 511, 511, 511, 511, C_GROUND, 2'd0);

        // Streamed coordinates: a new request each cycle, results two cycles behind.
        for (int j = 0; j <= 8; j++) begin
            if (j < 8) begin
                c = model_code(0, 2'd1, px_l[j], py_l[j]);
                drive_xy(0, px_l[j], py_l[j], px_l[7 - j], py_l[7 - j]);
                sb.push_back('{$sformatf("stream%0d", j),
                               (c < 0) ? C_NULL : col_of(2'(c)),
                               (model_code(0, 2'd1, px_l[7 - j], py_l[7 - j]) < 0) ? 2'd2 :
                               2'(model_code(0, 2'd1, px_l[7 - j], py_l[7 - j]))});
            end
            step();
            if (j >= 1) pop_check(0);
        end

        // Asynchronous reset in the middle of a cycle.
        drive_xy(0, 85, 40, 85, 40);
        step();
        #3 rst = 1'b1;
        #1;
        chk("async_rst_color", 32'(color_a), 32'(C_NULL));
        chk("async_rst_qtile", 32'(q_tile_a), 32'd2);
        chk("async_rst_busy", 32'(busy_a), 32'd0);
        step();
        rst = 1'b0;
        pix(0, "after_rst", 85, 40, 85, 40, C_NULL, 2'd2);

        // Level 2 with a level-3 load request while busy.
        watch_load(0, "load_l2", 2'd2, 1024, 100, 2'd3, -1);
        pix(0, "l2_goal", 32, 0, 32, 0, C_GOAL, 2'd3);
        pix(0, "l2_ground", 85, 40, 85, 40, C_GROUND, 2'd0);

        // Reset at cycle 500 of a level-1 load, then a clean level-0 load.
        watch_load(0, "abort_l1", 2'd1, 1024, -1, 2'd0, 500);
        pix(0, "after_abort", 48, 0, 48, 0, C_NULL, 2'd2);
        watch_load(0, "load_l0", 2'd0, 1024, -1, 2'd0, -1);
        pix(0, "l0_goal", 48, 0, 48, 0, C_GOAL, 2'd3);
        pix(0, "l0_wall", 16, 0, 16, 0, C_WALL, 2'd1);

        // Small grid: 8x8 tiles, 16x16 map.
        watch_load(1, "b_load_l1", 2'd1, 256, -1, 2'd2, -1);
        pix(1, "b_x128", 128, 0, 128, 0, C_NULL, 2'd2);
        pix(1, "b_tile_15_1", 127, 8, 127, 8, C_BOUND, 2'd2);
        pix(1, "b_tile_3_0", 24, 0, 24, 0, C_WALL, 2'd1);
        pix(1, "b_y128", 0, 128, 0, 128, C_NULL, 2'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
